// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin scheduler: widths, opcodes,
// sequencer state encoding and the latched request payload.
package alu_pkg;

  localparam int unsigned ALU_W  = 32;
  localparam int unsigned CALC_W = 33;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR = 3'b101;
  localparam logic [OP_W-1:0] OP_SLL = 3'b110;
  localparam logic [OP_W-1:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RESP  = 2'b10
  } sched_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ALU_W-1:0] b;
    logic [ALU_W-1:0] a;
  } alu_req_t;

  // Settle counter width; at least one bit even when SETTLE is 1.
  function automatic int unsigned cnt_width(int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [IDW-1:0]     gnt_idx_c_o,
  output logic               gnt_any_c_o
);

  always_comb begin
    int unsigned cand;
    logic        found;
    logic [IDW-1:0] idx;
    cand  = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
    gnt_any_c_o = found;
    gnt_idx_c_o = idx;
    gnt_c_o     = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external ALU between NUM_REQ requesters: round-robin grant,
// hold operands for SETTLE cycles, capture Calc, return it with the owner ID.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned SETTLE  = 1,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic [NUM_REQ-1:0]       ReqValid,
  output logic [NUM_REQ-1:0]       ReqReady,
  input  logic [ALU_W*NUM_REQ-1:0] ReqA,
  input  logic [ALU_W*NUM_REQ-1:0] ReqB,
  input  logic [OP_W*NUM_REQ-1:0]  ReqOp,
  output logic [ALU_W-1:0]         AluA,
  output logic [ALU_W-1:0]         AluB,
  output logic [OP_W-1:0]          AluOp,
  input  logic [CALC_W-1:0]        AluCalc,
  output logic                     RspValid,
  input  logic                     RspReady,
  output logic [CALC_W-1:0]        RspData,
  output logic [IDW-1:0]           RspId,
  output logic                     Busy
);

  localparam int unsigned CNT_W = cnt_width(SETTLE);

  sched_state_e        state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  alu_req_t            op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [CALC_W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic                busy_q;

  logic [NUM_REQ-1:0]  gnt_c;
  logic [IDW-1:0]      gnt_idx_c;
  logic                gnt_any_c;
  alu_req_t            sel_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i       (ReqValid),
    .ptr_i       (ptr_q),
    .gnt_c_o     (gnt_c),
    .gnt_idx_c_o (gnt_idx_c),
    .gnt_any_c_o (gnt_any_c)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        sel_c.a  = ReqA[ALU_W*i +: ALU_W];
        sel_c.b  = ReqB[ALU_W*i +: ALU_W];
        sel_c.op = ReqOp[OP_W*i +: OP_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ReqReady    = '0;
    unique case (state_q)
      S_IDLE: begin
        // Grant is suppressed while reset is asserted so ReqReady reads zero.
        if (Reset_n) ReqReady = gnt_c;
        if (gnt_any_c) begin
          op_d     = sel_c;
          rsp_id_d = gnt_idx_c;
          ptr_d    = (32'(gnt_idx_c) == NUM_REQ - 1) ? '0 : gnt_idx_c + IDW'(1);
          cnt_d    = CNT_W'(SETTLE - 1);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          rsp_data_d  = AluCalc;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign AluA     = op_q.a;
  assign AluB     = op_q.b;
  assign AluOp    = op_q.op;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspId    = rsp_id_q;
  assign Busy     = busy_q;

endmodule
